// File: rtl/udp_hdr_pkg.sv
// Shared definitions for udp_hdr_extract: FSM encodings, field byte offsets,
// header word bit positions and field widths.
package udp_hdr_pkg;

   typedef enum logic [1:0] {
      HDR0 = 2'd0,
      HDR1 = 2'd1,
      BODY = 2'd2
   } hdr_state_e;

   // Byte offsets within the beat that carries each field.
   localparam int VLAN_OFF   = 14;
   localparam int IPLEN_OFF  = 20;
   localparam int SRC_HI_OFF = 30;
   localparam int SRC_LO_OFF = 0;
   localparam int DST_OFF    = 2;
   localparam int SPORT_OFF  = 6;
   localparam int DPORT_OFF  = 8;

   localparam int VLAN_W = 12;
   localparam int LEN_W  = 16;
   localparam int IP_W   = 32;
   localparam int PORT_W = 16;
   localparam int HDR_W  = 128;

   localparam int HDR_SHORT_BIT = 127;
   localparam int HDR_VLAN_LSB  = 112;
   localparam int HDR_LEN_LSB   = 96;
   localparam int HDR_SRC_LSB   = 64;
   localparam int HDR_DST_LSB   = 32;
   localparam int HDR_SPORT_LSB = 16;
   localparam int HDR_DPORT_LSB = 0;

   // Big-endian 16-bit field starting at byte off of a 256-bit beat.
   function automatic logic [15:0] be16(input logic [255:0] d, input int off);
      return {d[8*off +: 8], d[8*(off+1) +: 8]};
   endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// First-word-fall-through synchronous FIFO with a registered output stage.
// Capacity is 2**DEPTH_LOG entries, counting the word held in the output register.
module axis_sync_fifo #(
   parameter int WIDTH     = 8,
   parameter int DEPTH_LOG = 3
) (
   input  logic             clk,
   input  logic             aresetn,
   input  logic [WIDTH-1:0] wr_data_i,
   input  logic             wr_en_i,
   output logic             full_o,
   output logic [WIDTH-1:0] rd_data_o,
   output logic             rd_valid_o,
   input  logic             rd_en_i
);
   localparam int DEPTH = 1 << DEPTH_LOG;
   localparam logic [DEPTH_LOG:0]   CNT_ONE  = (DEPTH_LOG+1)'(1);
   localparam logic [DEPTH_LOG:0]   CNT_FULL = (DEPTH_LOG+1)'(DEPTH);
   localparam logic [DEPTH_LOG-1:0] PTR_ONE  = DEPTH_LOG'(1);

   logic [WIDTH-1:0]     mem_q [DEPTH];
   logic [DEPTH_LOG-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [DEPTH_LOG:0]   count_q, count_d, mem_cnt_q, mem_cnt_d;
   logic [WIDTH-1:0]     out_q, out_d;
   logic                 out_vld_q, out_vld_d;
   logic                 push, pop, load, bypass, mem_wr;

   assign full_o     = (count_q == CNT_FULL);
   assign rd_data_o  = out_q;
   assign rd_valid_o = out_vld_q;

   always_comb begin
      pop       = rd_en_i && out_vld_q;
      push      = wr_en_i && (!full_o || pop);
      load      = (pop || !out_vld_q) && (mem_cnt_q != '0);
      bypass    = push && (pop || !out_vld_q) && (mem_cnt_q == '0);
      mem_wr    = push && !bypass;
      out_d     = out_q;
      out_vld_d = out_vld_q;
      rd_ptr_d  = rd_ptr_q;
      wr_ptr_d  = mem_wr ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      if (load) begin
         out_d     = mem_q[rd_ptr_q];
         out_vld_d = 1'b1;
         rd_ptr_d  = rd_ptr_q + PTR_ONE;
      end else if (bypass) begin
         out_d     = wr_data_i;
         out_vld_d = 1'b1;
      end else if (pop) begin
         out_vld_d = 1'b0;
      end
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
      mem_cnt_d = mem_cnt_q;
      case ({mem_wr, load})
         2'b10:   mem_cnt_d = mem_cnt_q + CNT_ONE;
         2'b01:   mem_cnt_d = mem_cnt_q - CNT_ONE;
         default: mem_cnt_d = mem_cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         mem_cnt_q <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         mem_cnt_q <= mem_cnt_d;
         out_q     <= out_d;
         out_vld_q <= out_vld_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

endmodule

// File: rtl/udp_hdr_extract.sv
// Passes VLAN/IPv4/UDP frames through a data FIFO and emits one 128-bit header
// word per packet. Define UDP_HDR_EXTRACT_STATS_EN to add packet counters.
module udp_hdr_extract
   import udp_hdr_pkg::*;
#(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int DATA_FIFO_DEPTH_LOG  = 5,
   parameter int HDR_FIFO_DEPTH_LOG   = 3
) (
   input  logic                              clk,
   input  logic                              aresetn,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
   input  logic                              s_axis_tvalid,
   input  logic                              s_axis_tlast,
   output logic                              s_axis_tready,
   output logic [C_S_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
   output logic [C_S_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
   output logic [C_S_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
   output logic                              m_axis_tvalid,
   output logic                              m_axis_tlast,
   input  logic                              m_axis_tready,
   output logic [HDR_W-1:0]                  m_hdr_tdata,
   output logic                              m_hdr_tvalid,
   input  logic                              m_hdr_tready,
   output logic [1:0]                        dbg_state_o
`ifdef UDP_HDR_EXTRACT_STATS_EN
   ,
   output logic [31:0]                       stat_pkt_cnt,
   output logic [31:0]                       stat_short_cnt
`endif
);
   localparam int DATA_FIFO_W = C_S_AXIS_DATA_WIDTH + C_S_AXIS_DATA_WIDTH/8 + C_S_AXIS_TUSER_WIDTH + 1;

   hdr_state_e          state_q, state_d;
   logic [VLAN_W-1:0]   vlan_q, vlan_d, cur_vlan;
   logic [LEN_W-1:0]    len_q, len_d, cur_len;
   logic [15:0]         src_hi_q, src_hi_d, cur_src_hi, cur_src_lo;
   logic [IP_W-1:0]     cur_dst;
   logic [PORT_W-1:0]   cur_sport, cur_dport;
   logic [HDR_W-1:0]    hdr_word;
   logic                hdr_push, beat_acc, data_full, hdr_full;

   // Any accepted beat needs room for itself and possibly a header word.
   assign s_axis_tready = aresetn && !data_full && !hdr_full;
   assign beat_acc      = s_axis_tvalid && s_axis_tready;
   assign dbg_state_o   = state_q;

   assign cur_vlan   = VLAN_W'(be16(s_axis_tdata, VLAN_OFF));
   assign cur_len    = be16(s_axis_tdata, IPLEN_OFF);
   assign cur_src_hi = be16(s_axis_tdata, SRC_HI_OFF);
   assign cur_src_lo = be16(s_axis_tdata, SRC_LO_OFF);
   assign cur_dst    = {be16(s_axis_tdata, DST_OFF), be16(s_axis_tdata, DST_OFF+2)};
   assign cur_sport  = be16(s_axis_tdata, SPORT_OFF);
   assign cur_dport  = be16(s_axis_tdata, DPORT_OFF);

   always_comb begin
      state_d  = state_q;
      vlan_d   = vlan_q;
      len_d    = len_q;
      src_hi_d = src_hi_q;
      hdr_push = 1'b0;
      hdr_word = '0;
      if (beat_acc) begin
         unique case (state_q)
            HDR0: begin
               vlan_d   = cur_vlan;
               len_d    = cur_len;
               src_hi_d = cur_src_hi;
               if (s_axis_tlast) begin
                  hdr_push                              = 1'b1;
                  hdr_word[HDR_SHORT_BIT]               = 1'b1;
                  hdr_word[HDR_VLAN_LSB +: VLAN_W]      = cur_vlan;
                  hdr_word[HDR_LEN_LSB +: LEN_W]        = cur_len;
                  hdr_word[HDR_SRC_LSB+16 +: 16]        = cur_src_hi;
               end else begin
                  state_d = HDR1;
               end
            end
            HDR1: begin
               hdr_push                              = 1'b1;
               hdr_word[HDR_VLAN_LSB +: VLAN_W]      = vlan_q;
               hdr_word[HDR_LEN_LSB +: LEN_W]        = len_q;
               hdr_word[HDR_SRC_LSB +: IP_W]         = {src_hi_q, cur_src_lo};
               hdr_word[HDR_DST_LSB +: IP_W]         = cur_dst;
               hdr_word[HDR_SPORT_LSB +: PORT_W]     = cur_sport;
               hdr_word[HDR_DPORT_LSB +: PORT_W]     = cur_dport;
               state_d = s_axis_tlast ? HDR0 : BODY;
            end
            BODY:    if (s_axis_tlast) state_d = HDR0;
            default: state_d = HDR0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         state_q  <= HDR0;
         vlan_q   <= '0;
         len_q    <= '0;
         src_hi_q <= '0;
      end else begin
         state_q  <= state_d;
         vlan_q   <= vlan_d;
         len_q    <= len_d;
         src_hi_q <= src_hi_d;
      end
   end

   axis_sync_fifo #(.WIDTH(DATA_FIFO_W), .DEPTH_LOG(DATA_FIFO_DEPTH_LOG)) u_data_fifo (
      .clk        (clk),
      .aresetn    (aresetn),
      .wr_data_i  ({s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast}),
      .wr_en_i    (beat_acc),
      .full_o     (data_full),
      .rd_data_o  ({m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast}),
      .rd_valid_o (m_axis_tvalid),
      .rd_en_i    (m_axis_tready)
   );

   axis_sync_fifo #(.WIDTH(HDR_W), .DEPTH_LOG(HDR_FIFO_DEPTH_LOG)) u_hdr_fifo (
      .clk        (clk),
      .aresetn    (aresetn),
      .wr_data_i  (hdr_word),
      .wr_en_i    (hdr_push),
      .full_o     (hdr_full),
      .rd_data_o  (m_hdr_tdata),
      .rd_valid_o (m_hdr_tvalid),
      .rd_en_i    (m_hdr_tready)
   );

`ifdef UDP_HDR_EXTRACT_STATS_EN
   logic [31:0] pkt_cnt_q, short_cnt_q;

   always_ff @(posedge clk) begin
      if (!aresetn) begin
         pkt_cnt_q   <= '0;
         short_cnt_q <= '0;
      end else begin
         if (hdr_push)                            pkt_cnt_q   <= pkt_cnt_q + 32'd1;
         if (hdr_push && hdr_word[HDR_SHORT_BIT]) short_cnt_q <= short_cnt_q + 32'd1;
      end
   end

   assign stat_pkt_cnt   = pkt_cnt_q;
   assign stat_short_cnt = short_cnt_q;
`endif

endmodule

// File: tb/tb_udp_hdr_extract.sv
// Directed bench for udp_hdr_extract with scoreboard queues for both output streams.
module tb_udp_hdr_extract;

   typedef struct {
      logic [11:0] vlan;
      logic [15:0] len;
      logic [31:0] src;
      logic [31:0] dst;
      logic [15:0] sp;
      logic [15:0] dp;
   } pkt_t;

   logic         clk = 1'b0;
   logic         aresetn;
   logic [255:0] s_axis_tdata;
   logic [31:0]  s_axis_tkeep;
   logic [127:0] s_axis_tuser;
   logic         s_axis_tvalid, s_axis_tlast, s_axis_tready;
   logic [255:0] m_axis_tdata;
   logic [31:0]  m_axis_tkeep;
   logic [127:0] m_axis_tuser;
   logic         m_axis_tvalid, m_axis_tlast, m_axis_tready;
   logic [127:0] m_hdr_tdata;
   logic         m_hdr_tvalid, m_hdr_tready;
   logic [1:0]   dbg_state_o;
`ifdef UDP_HDR_EXTRACT_STATS_EN
   logic [31:0]  stat_pkt_cnt, stat_short_cnt;
`endif

   int tests_run = 0;
   int tests_failed = 0;
   logic [416:0] data_exp_q[$];
   logic [127:0] hdr_exp_q[$];

   always #5 clk = ~clk;

   udp_hdr_extract dut (
      .clk           (clk),
      .aresetn       (aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tkeep  (s_axis_tkeep),
      .s_axis_tuser  (s_axis_tuser),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tkeep  (m_axis_tkeep),
      .m_axis_tuser  (m_axis_tuser),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .m_hdr_tdata   (m_hdr_tdata),
      .m_hdr_tvalid  (m_hdr_tvalid),
      .m_hdr_tready  (m_hdr_tready),
      .dbg_state_o   (dbg_state_o)
`ifdef UDP_HDR_EXTRACT_STATS_EN
      ,
      .stat_pkt_cnt  (stat_pkt_cnt),
      .stat_short_cnt(stat_short_cnt)
`endif
   );

   // ---------------- scoreboard monitors ----------------
   logic [416:0] mon_d_got, mon_d_exp;
   logic [127:0] mon_h_exp;

   always @(negedge clk) begin
      if (aresetn && m_axis_tvalid && m_axis_tready) begin
         mon_d_got = {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast};
         mon_d_exp = (data_exp_q.size() != 0) ? data_exp_q.pop_front() : 'x;
         tests_run++;
         assert (mon_d_got === mon_d_exp) else begin
            tests_failed++;
            $error("FAIL data_beat got=%h exp=%h", mon_d_got, mon_d_exp);
         end
      end
      if (aresetn && m_hdr_tvalid && m_hdr_tready) begin
         mon_h_exp = (hdr_exp_q.size() != 0) ? hdr_exp_q.pop_front() : 'x;
         tests_run++;
         assert (m_hdr_tdata === mon_h_exp) else begin
            tests_failed++;
            $error("FAIL hdr_word got=%h exp=%h", m_hdr_tdata, mon_h_exp);
         end
      end
   end

   // ---------------- check helpers ----------------
   task automatic chk_bit(input string tag, input logic got, input logic exp);
      tests_run++;
      assert (got === exp) else begin
         tests_failed++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic chk_vec(input string tag, input logic [255:0] got, input logic [255:0] exp);
      tests_run++;
      assert (got === exp) else begin
         tests_failed++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_int(input string tag, input int got, input int exp);
      tests_run++;
      assert (got == exp) else begin
         tests_failed++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // ---------------- stimulus model ----------------
   function automatic logic [255:0] put16(input logic [255:0] d, input int off, input logic [15:0] v);
      logic [255:0] r;
      r = d;
      r[8*off +: 8]     = v[15:8];
      r[8*(off+1) +: 8] = v[7:0];
      return r;
   endfunction

   function automatic logic [255:0] build_beat(input int idx, input pkt_t p);
      logic [255:0] r;
      logic [3:0]   pcp;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom();
      pcp = 4'($urandom_range(0, 15));
      if (idx == 0) begin
         r = put16(r, 14, {pcp, p.vlan});
         r = put16(r, 20, p.len);
         r = put16(r, 30, p.src[31:16]);
      end else if (idx == 1) begin
         r = put16(r, 0, p.src[15:0]);
         r = put16(r, 2, p.dst[31:16]);
         r = put16(r, 4, p.dst[15:0]);
         r = put16(r, 6, p.sp);
         r = put16(r, 8, p.dp);
      end
      return r;
   endfunction

   function automatic logic [127:0] exp_hdr(input logic short_pkt, input pkt_t p);
      if (short_pkt) return {1'b1, 3'b000, p.vlan, p.len, p.src[31:16], 16'h0, 64'h0};
      return {1'b0, 3'b000, p.vlan, p.len, p.src, p.dst, p.sp, p.dp};
   endfunction

   function automatic pkt_t rand_pkt();
      pkt_t p;
      p.vlan = 12'($urandom());
      p.len  = 16'($urandom());
      p.src  = $urandom();
      p.dst  = $urandom();
      p.sp   = 16'($urandom());
      p.dp   = 16'($urandom());
      return p;
   endfunction

   task automatic finish_now();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   endtask

   // ---------------- driver tasks ----------------
   // Presents one beat and returns #1 after the edge that accepted it.
   task automatic drive_beat(input logic [255:0] d, input logic last, output int stalls);
      logic [31:0]  k;
      logic [127:0] u;
      logic         rdy;
      k = $urandom();
      u = {$urandom(), $urandom(), $urandom(), $urandom()};
      s_axis_tdata  = d;
      s_axis_tkeep  = k;
      s_axis_tuser  = u;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      stalls = 0;
      forever begin
         @(negedge clk);
         rdy = s_axis_tready;
         @(posedge clk);
         if (rdy) break;
         stalls++;
         if (stalls > 500) begin
            tests_failed++;
            $display("FAIL drive_timeout got=no_tready exp=tready_within_500");
            $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
            $fatal(1, "input stalled");
         end
      end
      data_exp_q.push_back({d, k, u, last});
      #1;
      s_axis_tvalid = 1'b0;
   endtask

   task automatic send_pkt(input int nbeats, input pkt_t p, output int stalls_total);
      int st;
      stalls_total = 0;
      hdr_exp_q.push_back(exp_hdr(nbeats == 1, p));
      for (int b = 0; b < nbeats; b++) begin
         drive_beat(build_beat(b, p), b == nbeats - 1, st);
         stalls_total += st;
      end
   endtask

   task automatic drain();
      int cyc;
      cyc = 0;
      while ((data_exp_q.size() != 0 || hdr_exp_q.size() != 0) && cyc < 300) begin
         @(posedge clk);
         cyc++;
      end
      @(posedge clk);
      #1;
      chk_int("drain_data_q", data_exp_q.size(), 0);
      chk_int("drain_hdr_q", hdr_exp_q.size(), 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      pkt_t p;
      int   st, tot;
      logic [255:0] held;

      aresetn       = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tkeep  = '0;
      s_axis_tuser  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;
      m_hdr_tready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_bit("rst_s_tready", s_axis_tready, 1'b0);
      chk_bit("rst_m_tvalid", m_axis_tvalid, 1'b0);
      chk_bit("rst_hdr_tvalid", m_hdr_tvalid, 1'b0);
      chk_vec("rst_m_tdata", m_axis_tdata, '0);
      chk_vec("rst_hdr_tdata", {128'h0, m_hdr_tdata}, '0);
      chk_int("rst_state", int'(dbg_state_o), 0);
      aresetn = 1'b1;
      @(posedge clk);
      #1;
      chk_bit("post_rst_tready", s_axis_tready, 1'b1);

      // Reference packet with known header value and latency checks.
      p.vlan = 12'h123; p.len = 16'h0040; p.src = 32'h0A000001;
      p.dst  = 32'h0A000002; p.sp = 16'h1234; p.dp = 16'h5678;
      hdr_exp_q.push_back(128'h0123_0040_0A000001_0A000002_1234_5678);
      drive_beat(build_beat(0, p), 1'b0, st);
      chk_bit("data_latency", m_axis_tvalid, 1'b1);
      drive_beat(build_beat(1, p), 1'b0, st);
      chk_bit("hdr_latency", m_hdr_tvalid, 1'b1);
      chk_vec("hdr_ref_value", {128'h0, m_hdr_tdata}, {128'h0, 128'h0123_0040_0A000001_0A000002_1234_5678});
      drive_beat(build_beat(2, p), 1'b1, st);
      drain();

      // Single-beat packet gives a short header.
      p = rand_pkt();
      send_pkt(1, p, st);
      chk_bit("short_hdr_valid", m_hdr_tvalid, 1'b1);
      chk_bit("short_bit", m_hdr_tdata[127], 1'b1);
      chk_vec("short_low64", {192'h0, m_hdr_tdata[63:0]}, '0);
      drain();

      // Back-to-back two-beat packets with no input stall.
      tot = 0;
      for (int i = 0; i < 6; i++) begin
         send_pkt(2, rand_pkt(), st);
         tot += st;
      end
      chk_int("b2b_stalls", tot, 0);
      drain();

      // Header consumer stalled: input blocks once 8 headers are queued.
      m_hdr_tready = 1'b0;
      tot = 0;
      for (int i = 0; i < 8; i++) begin
         send_pkt(2, rand_pkt(), st);
         tot += st;
      end
      chk_int("hdr_fill_stalls", tot, 0);
      chk_bit("hdr_full_tready", s_axis_tready, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      chk_bit("hdr_full_hold", s_axis_tready, 1'b0);
      chk_bit("hdr_held_valid", m_hdr_tvalid, 1'b1);
      m_hdr_tready = 1'b1;
      send_pkt(2, rand_pkt(), st);
      send_pkt(3, rand_pkt(), st);
      drain();

      // Data consumer stalled: input blocks after 32 beats.
      m_axis_tready = 1'b0;
      tot = 0;
      for (int i = 0; i < 8; i++) begin
         send_pkt(4, rand_pkt(), st);
         tot += st;
      end
      chk_int("data_fill_stalls", tot, 0);
      chk_bit("data_full_tready", s_axis_tready, 1'b0);
      held = m_axis_tdata;
      repeat (3) @(posedge clk);
      #1;
      chk_bit("data_held_valid", m_axis_tvalid, 1'b1);
      chk_vec("data_held_stable", m_axis_tdata, held);
      m_axis_tready = 1'b1;
      send_pkt(2, rand_pkt(), st);
      send_pkt(1, rand_pkt(), st);
      drain();

      // Reset in the body of a 5-beat packet discards everything buffered.
      p = rand_pkt();
      hdr_exp_q.push_back(exp_hdr(1'b0, p));
      for (int b = 0; b < 3; b++) drive_beat(build_beat(b, p), 1'b0, st);
      chk_int("pre_rst_state", int'(dbg_state_o), 2);
      aresetn = 1'b0;
      data_exp_q.delete();
      hdr_exp_q.delete();
      @(posedge clk);
      #1;
      chk_bit("midrst_m_tvalid", m_axis_tvalid, 1'b0);
      chk_bit("midrst_hdr_tvalid", m_hdr_tvalid, 1'b0);
      chk_bit("midrst_s_tready", s_axis_tready, 1'b0);
      chk_int("midrst_state", int'(dbg_state_o), 0);
      aresetn = 1'b1;
      @(posedge clk);
      #1;
      send_pkt(3, rand_pkt(), st);
      send_pkt(1, rand_pkt(), st);
      drain();
      chk_bit("end_m_tvalid", m_axis_tvalid, 1'b0);

      finish_now();
   end

endmodule

// File: doc/udp_hdr_extract.md
# udp_hdr_extract

Stage directly downstream of the UDP packet filter. Accepts the filtered 256-bit AXI-Stream of VLAN-tagged IPv4/UDP frames and forwards every beat unchanged through a data FIFO. From the first two beats of each packet it captures the VLAN ID, IP total length, IP addresses and UDP ports. It emits these fields as one 128-bit header word per packet on a separate AXI-Stream, which feeds the downstream parser/PHV stage.

## Interface
- C_S_AXIS_DATA_WIDTH, 256, data bus width; fixed at 256, since field offsets assume it.
- C_S_AXIS_TUSER_WIDTH, 128, tuser width; carried through unchanged.
- DATA_FIFO_DEPTH_LOG, 5, log2 depth of the data FIFO (32 beats).
- HDR_FIFO_DEPTH_LOG, 3, log2 depth of the header FIFO (8 words).
- clk  in  1  clock.
- aresetn  in  1  synchronous, active-low reset.
- s_axis_tdata/tkeep/tuser/tvalid/tlast  in  256/32/128/1/1  input stream.
- s_axis_tready  out  1  accept input.
- m_axis_tdata/tkeep/tuser/tvalid/tlast  out  256/32/128/1/1  passthrough stream.
- m_axis_tready  in  1  downstream ready.
- m_hdr_tdata  out  128  header word.
- m_hdr_tvalid  out  1  header word valid.
- m_hdr_tready  in  1  header consumer ready.

## Operation
- Byte n of a beat is tdata[8n+7:8n]. Multi-byte fields are assembled big-endian: the first wire byte becomes the MSB.
- Beat 0 fields:
  - vlan_id = bytes 14–15, low 12 bits.
  - ip_len = bytes 20–21.
  - src_ip[31:16] = bytes 30–31.
- Beat 1 fields:
  - src_ip[15:0] = bytes 0–1.
  - dst_ip = bytes 2–5.
  - sport = bytes 6–7.
  - dport = bytes 8–9.
- m_hdr_tdata layout:
  - [127] short: packet ended on beat 0.
  - [126:124] zero.
  - [123:112] vlan_id.
  - [111:96] ip_len.
  - [95:64] src_ip.
  - [63:32] dst_ip.
  - [31:16] sport.
  - [15:0] dport.
- Input handshake: a beat transfers when s_axis_tvalid && s_axis_tready. s_axis_tready = !data_fifo_full && !hdr_fifo_full. This is combinational from FIFO flags and low during reset.
- State machine (states HDR0, HDR1, BODY; reset state HDR0). Each transition happens only on an accepted beat:
  - HDR0: latch the beat-0 fields.
    - tlast=1: push a header word with short=1 and all beat-1 fields zero; stay in HDR0.
    - Otherwise: go to HDR1.
  - HDR1: combine with the latched fields and push the header word with short=0.
    - tlast=1: go to HDR0.
    - Otherwise: go to BODY.
  - BODY: tlast=1 goes to HDR0.
- Every accepted beat is pushed to the data FIFO as {tdata, tkeep, tuser, tlast}. No beat is dropped, reordered or modified.
- The two output streams are independent. A stalled m_hdr_tready backpressures input only once the header FIFO is full.
- A header push and a header pop in the same cycle are both legal, including when the FIFO is full.

## Timing
- Reset values: m_axis_tvalid=0, m_hdr_tvalid=0, s_axis_tready=0, all data outputs 0. Both FIFOs are emptied and state = HDR0.
- Reset asserted mid-packet discards all buffered beats and headers. The first beat after reset is treated as beat 0.
- Data latency: a beat accepted in cycle t is valid on m_axis in cycle t+1 if the FIFO was empty.
- Header latency: the header word is valid in cycle t+1 after its pushing beat (HDR1 beat, or short HDR0 beat) is accepted in cycle t.
- Outputs are registered. While a valid is held, its data is stable until the matching ready arrives.
- Throughput: one beat per cycle sustained while both readies are high.
- Full boundary: with the data FIFO at depth-1 and a push with no pop, tready drops the next cycle. No overflow is ever possible.

## Configuration
- UDP_HDR_EXTRACT_STATS_EN defined: adds outputs stat_pkt_cnt[31:0] and stat_short_cnt[31:0].
  - stat_pkt_cnt increments on every header push.
  - stat_short_cnt increments on every push with short=1.
  - Both counters wrap at 2^32 and are zeroed by reset.
- Not defined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package/header udp_hdr_pkg holds:
  - state encodings (HDR0=0, HDR1=1, BODY=2);
  - byte offsets of every field;
  - m_hdr_tdata bit positions;
  - field widths.
- One sub-module, axis_sync_fifo: parameterized width and depth log, first-word-fall-through, registered output, full/empty flags. It is instantiated twice, once for data (417 bits) and once for header (128 bits).

## Test plan
- Single 3-beat packet with vlan 0x123, ip_len 0x0040, src 10.0.0.1, dst 10.0.0.2, sport 0x1234, dport 0x5678, both readies high → 3 identical beats out; one header 0x0123_0040_0A000001_0A000002_1234_5678 (bit 127=0).
- 1-beat packet (tlast on beat 0) → header with bit 127=1 and bits [63:0]=0; the beat is passed through.
- Back-to-back 2-beat packets, continuous valid → headers emitted in order; s_axis_tready never drops.
- m_hdr_tready held low for 10 packets → tready drops after the 8th header is pushed; no header is lost after release.
- m_axis_tready held low → tready low after 32 beats; data and headers resume in order after release.
- Reset asserted during BODY of a 5-beat packet → all valids 0 next cycle; the following packet is parsed correctly from beat 0.
